// File: rtl/dffnsre_bank_reader.sv
// dffnsre_bank_reader
// Snapshots the gated Q lanes of an 8-lane negative-edge flop bank on a
// capture request. The captured word is returned as a serial bit stream,
// LSB first, followed by an optional parity bit.
//
// Ports:
//   C         clock, all state updates on the rising edge
//   R         synchronous active-high reset
//   Q_in      bank Q lanes (already gated by the bank's sel)
//   sel_in    bank sel, sampled with Q_in to produce desel
//   cap_req   capture request, level-sampled every cycle
//   ovr_clr   clears the sticky overrun flag
//   tx_ready  sink accepts the current bit
//   tx_data   current serial bit
//   tx_valid  tx_data is valid
//   tx_last   current bit is the final bit of the frame
//   busy      a frame is in progress
//   desel     sel_in was 0 at the last capture
//   overrun   sticky: cap_req seen while busy and not taken
//   state     debug view of the FSM state (0 IDLE, 1 SHIFT, 2 PAR)
//
// Handshake: a bit transfers on a rising edge where tx_valid && tx_ready.
// Once tx_valid rises it stays high until the frame's last bit transfers.
// tx_data and tx_last do not change while tx_valid && !tx_ready.
// Every output is decoded from registered state only, so neither tx_ready
// nor cap_req has a combinational path to an output.
module dffnsre_bank_reader #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] Q_in,
  input  logic             sel_in,
  input  logic             cap_req,
  input  logic             ovr_clr,
  input  logic             tx_ready,
  output logic             tx_data,
  output logic             tx_valid,
  output logic             tx_last,
  output logic             busy,
  output logic             desel,
  output logic             overrun,
  output logic [1:0]       state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t           st;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt;
  logic             par_q;
  logic             desel_q;
  logic             overrun_q;

  logic at_last;    // SHIFT is presenting data bit WIDTH-1
  logic fire;       // current bit transfers on this edge
  logic final_acc;  // the frame's final bit transfers on this edge
  logic take_cap;   // a capture is loaded on this edge
  logic ovr_evt;    // a request arrived that cannot be taken

  assign at_last   = (st == SHIFT) && (cnt == LAST_IDX);
  assign tx_valid  = (st == SHIFT) || (st == PAR);
  assign busy      = tx_valid;
  assign tx_data   = (st == PAR)   ? par_q :
                     (st == SHIFT) ? shift_q[0] : 1'b0;
  assign tx_last   = (st == PAR) || (at_last && !PARITY_EN);
  assign fire      = tx_valid && tx_ready;
  assign final_acc = fire && tx_last;
  // The final-accept cycle counts as idle for capture purposes, which
  // gives back-to-back frames with no gap.
  assign take_cap  = cap_req && ((st == IDLE) || final_acc);
  assign ovr_evt   = cap_req && busy && !final_acc;

  assign desel   = desel_q;
  assign overrun = overrun_q;
  assign state   = st;

  always_ff @(posedge C) begin
    if (R) begin
      st        <= IDLE;
      shift_q   <= '0;
      cnt       <= '0;
      par_q     <= 1'b0;
      desel_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // Set wins over clear when both land in the same cycle.
      overrun_q <= ovr_evt | (overrun_q & ~ovr_clr);

      if (take_cap) begin
        shift_q <= Q_in;
        desel_q <= ~sel_in;
        par_q   <= (^Q_in) ^ ODD_PARITY;
        cnt     <= '0;
        st      <= SHIFT;
      end else begin
        case (st)
          IDLE: begin
            st <= IDLE;
          end
          SHIFT: begin
            if (fire) begin
              if (at_last) begin
                st <= PARITY_EN ? PAR : IDLE;
              end else begin
                shift_q <= {1'b0, shift_q[WIDTH-1:1]};
                cnt     <= cnt + 1'b1;
              end
            end
          end
          PAR: begin
            if (fire) begin
              st <= IDLE;
            end
          end
          default: begin
            st <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dffnsre_bank_reader.sv
// Testbench for dffnsre_bank_reader.
// Main instance uses the default parameters (WIDTH 8, even parity
// appended). A second instance with PARITY_EN=0 shares the inputs and is
// checked only in the parameter-variant sequence.
module tb_dffnsre_bank_reader;

  logic       C = 1'b0;
  logic       R;
  logic [7:0] Q_in;
  logic       sel_in;
  logic       cap_req;
  logic       ovr_clr;
  logic       tx_ready;

  logic       tx_data, tx_valid, tx_last, busy, desel, overrun;
  logic [1:0] state;

  logic       np_data, np_valid, np_last, np_busy, np_desel, np_overrun;
  logic [1:0] np_state;

  int n_checks = 0;
  int n_errors = 0;

  // Clock/reset
  always #5 C = ~C;

  dffnsre_bank_reader #(.WIDTH(8), .PARITY_EN(1'b1), .ODD_PARITY(1'b0)) u_dut (
    .C(C), .R(R), .Q_in(Q_in), .sel_in(sel_in), .cap_req(cap_req),
    .ovr_clr(ovr_clr), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .busy(busy), .desel(desel),
    .overrun(overrun), .state(state)
  );

  dffnsre_bank_reader #(.WIDTH(8), .PARITY_EN(1'b0), .ODD_PARITY(1'b0)) u_np (
    .C(C), .R(R), .Q_in(Q_in), .sel_in(sel_in), .cap_req(cap_req),
    .ovr_clr(ovr_clr), .tx_ready(tx_ready), .tx_data(np_data),
    .tx_valid(np_valid), .tx_last(np_last), .busy(np_busy), .desel(np_desel),
    .overrun(np_overrun), .state(np_state)
  );

  typedef struct {
    logic [7:0] q;
    logic       sel;
    logic       exp_par;
    logic       exp_desel;
    logic       bp;
  } vec_t;

  vec_t vecs[5];

  // Comparison helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks: advance one cycle, sample 1 ns after the rising edge.
  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic capture(input logic [7:0] q, input logic sel);
    Q_in    = q;
    sel_in  = sel;
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
  endtask

  // Scoreboard for one frame on the main instance, starting in the cycle
  // that presents bit0. Expected bits are queued LSB first, parity last.
  task automatic check_frame(input logic [7:0] q, input logic exp_par,
                             input logic bp, input logic chk_busy);
    logic [0:0] exp_q[$];
    int cyc;
    int busy_cnt;
    int idx;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(q[i]);
    exp_q.push_back(exp_par);
    cyc = 0;
    busy_cnt = 0;
    idx = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      chk("tx_valid_in_frame", tx_valid, 1);
      chk("tx_data", tx_data, exp_q[0]);
      chk("tx_last", tx_last, (idx == 8));
      if (busy) busy_cnt++;
      tx_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      cyc++;
      step();
      if (tx_ready) begin
        void'(exp_q.pop_front());
        idx++;
      end
    end
    if (exp_q.size() > 0) chk("frame_timeout", exp_q.size(), 0);
    tx_ready = 1'b1;
    chk("tx_valid_after_frame", tx_valid, 0);
    chk("busy_after_frame", busy, 0);
    if (chk_busy) chk("busy_cycles", busy_cnt, 9);
  endtask

  initial begin
    vecs[0] = '{q: 8'hA5, sel: 1'b1, exp_par: 1'b0, exp_desel: 1'b0, bp: 1'b0};
    vecs[1] = '{q: 8'hFF, sel: 1'b0, exp_par: 1'b0, exp_desel: 1'b1, bp: 1'b0};
    vecs[2] = '{q: 8'h01, sel: 1'b1, exp_par: 1'b1, exp_desel: 1'b0, bp: 1'b1};
    vecs[3] = '{q: 8'h7F, sel: 1'b1, exp_par: 1'b1, exp_desel: 1'b0, bp: 1'b0};
    vecs[4] = '{q: 8'h5A, sel: 1'b0, exp_par: 1'b0, exp_desel: 1'b1, bp: 1'b1};

    R = 1'b1; Q_in = '0; sel_in = 1'b1; cap_req = 1'b0; ovr_clr = 1'b0; tx_ready = 1'b1;
    step();
    step();
    R = 1'b0;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_desel", desel, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_state", state, 0);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      capture(vecs[v].q, vecs[v].sel);
      chk("desel_after_cap", desel, vecs[v].exp_desel);
      check_frame(vecs[v].q, vecs[v].exp_par, vecs[v].bp, !vecs[v].bp);
      chk("desel_held", desel, vecs[v].exp_desel);
    end
    chk("no_overrun_yet", overrun, 0);

    // Overrun in the 3rd bit cycle, then back-to-back capture of 3C
    capture(8'hA5, 1'b1);
    step();
    step();
    chk("bit2_before_ovr", tx_data, 1);
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
    chk("overrun_set", overrun, 1);
    chk("bit3_after_ovr", tx_data, 0);
    for (int i = 0; i < 4; i++) step();
    chk("bit7", tx_data, 1);
    step();
    chk("par_last", tx_last, 1);
    chk("par_data", tx_data, 0);
    Q_in = 8'h3C;
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_state", state, 1);
    chk("overrun_held", overrun, 1);
    check_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("overrun_cleared", overrun, 0);

    // Overrun set and clear in the same cycle: set wins
    capture(8'h5A, 1'b1);
    step();
    cap_req = 1'b1;
    ovr_clr = 1'b1;
    step();
    cap_req = 1'b0;
    ovr_clr = 1'b0;
    chk("overrun_set_wins", overrun, 1);
    for (int i = 0; i < 20 && busy; i++) step();
    chk("drain_idle", busy, 0);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("overrun_cleared2", overrun, 0);

    // Reset during bit 4
    capture(8'hF0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("bit4_before_rst", tx_data, 1);
    R = 1'b1;
    step();
    R = 1'b0;
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_tx_last", tx_last, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_desel", desel, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_state", state, 0);
    step();
    chk("midrst_stays_idle", tx_valid, 0);
    capture(8'h3C, 1'b1);
    check_frame(8'h3C, 1'b0, 1'b0, 1'b1);

    // Parameter variant: no parity bit, tx_last on bit7
    R = 1'b1;
    step();
    R = 1'b0;
    capture(8'h80, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("np_valid", np_valid, 1);
      chk("np_data", np_data, (i == 7));
      chk("np_last", np_last, (i == 7));
      step();
    end
    chk("np_valid_after", np_valid, 0);
    chk("np_busy_after", np_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
